mul_shift_add: RTL and testbench
================================

# mul_shift_add

Sequential shift-and-add unsigned multiplier controller that sits directly in front of, and behind, the two-operand `adder` stage. It:
- accepts an operand pair over a STB/ACK handshake;
- scans the multiplier bit by bit;
- issues one `ACC + (multiplicand << i)` request to the adder per set bit, and captures each sum back;
- presents the full-width product on a STB/ACK output.

The external `adder` instance is built with both widths equal to `A_WIDTH+B_WIDTH` and shares `CLK`/`RST` with this block.

## Interface
- `A_WIDTH`, 32, multiplicand width.
- `B_WIDTH`, 32, multiplier width; iteration count.
- `P_WIDTH`, `A_WIDTH+B_WIDTH`, product and accumulator width (derived, not overridden).

- `CLK`  in  1  clock, rising edge.
- `RST`  in  1  reset. **One clock; reset is synchronous and active-high.**
- `I_STB`  in  1  operand pair valid.
- `I_ACK`  out  1  operand pair accepted; `I_ACK = I_STB & (state==IDLE)`.
- `I_DAT_A`  in  `A_WIDTH`  multiplicand, unsigned.
- `I_DAT_B`  in  `B_WIDTH`  multiplier, unsigned.
- `ADD_STB`  out  1  adder request valid.
- `ADD_ACK`  in  1  adder accepted request.
- `ADD_DAT_A`  out  `P_WIDTH`  accumulator operand.
- `ADD_DAT_B`  out  `P_WIDTH`  shifted multiplicand operand.
- `ADD_RES_STB`  in  1  adder sum valid.
- `ADD_RES_DAT`  in  `P_WIDTH+1`  adder sum.
- `ADD_RES_ACK`  out  1  sum consumed; `ADD_RES_ACK = ADD_RES_STB & (state==IDLE | state==ADD_WAIT)`.
- `O_STB`  out  1  product valid.
- `O_DAT`  out  `P_WIDTH`  product.
- `O_ACK`  in  1  product consumed.

## Operation
- A transfer occurs on any rising edge where STB and ACK are both high.
- Registers:
  - `MCAND` (`P_WIDTH`), multiplicand.
  - `MPLIER` (`B_WIDTH`), multiplier.
  - `ACC` (`P_WIDTH`), accumulator.
  - `CNT` (`$clog2(B_WIDTH)+1`), bit counter.
- FSM states: IDLE, SCAN, ADD_REQ, ADD_WAIT, DONE.
  - **IDLE:** on `I_ACK`:
    - `MCAND` ← zero-extended `I_DAT_A`; `MPLIER` ← `I_DAT_B`; `ACC` ← 0; `CNT` ← 0.
    - Go to SCAN.
  - **SCAN:**
    - If `MPLIER[0]==1`, go to ADD_REQ.
    - Otherwise perform a *shift step*.
  - **ADD_REQ:**
    - `ADD_STB` = 1, `ADD_DAT_A` = `ACC`, `ADD_DAT_B` = `MCAND`.
    - On `ADD_ACK`, go to ADD_WAIT.
    - While `ADD_ACK` is low, `ADD_STB` and the data stay stable.
  - **ADD_WAIT:** on `ADD_RES_STB`:
    - `ACC` ← `ADD_RES_DAT[P_WIDTH-1:0]` (MSB discarded; the product cannot overflow `P_WIDTH`).
    - Same edge: shift step.
  - **Shift step:**
    - `MCAND` ← `MCAND<<1`; `MPLIER` ← `MPLIER>>1`; `CNT` ← `CNT+1`.
    - If `CNT==B_WIDTH-1` (last bit), go to DONE; else go to SCAN.
  - **DONE:**
    - `O_STB` = 1, `O_DAT` = `ACC`.
    - On `O_ACK`, go to IDLE.
    - While `O_ACK` is low, `O_STB`/`O_DAT` are held stable.
- `ADD_RES_ACK` is also asserted in IDLE, so stray adder results are drained.
- `O_STB`, `O_DAT`, `ADD_STB`, `ADD_DAT_A`/`B` are registered or decoded from state and registers only. No combinational path from input to output except `I_ACK` and `ADD_RES_ACK`.

## Timing
- Reset (synchronous, edge where `RST`=1):
  - State ← IDLE.
  - `MCAND`, `MPLIER`, `ACC`, `CNT` ← 0.
  - `O_STB`=0, `O_DAT`=0, `ADD_STB`=0, `ADD_DAT_A`=0, `ADD_DAT_B`=0.
  - `I_ACK` follows `I_STB` from the first post-reset cycle.
- Reset mid-operation: the operation is abandoned and no `O_STB` is produced. The shared `RST` also clears the adder.
- Adder with zero wait states (`ADD_ACK` combinational, sum valid the next cycle): a set bit costs 3 cycles (SCAN, ADD_REQ, ADD_WAIT); a clear bit costs 1 cycle.
- Latency, accept edge to first cycle of `O_STB` high: `1 + B_WIDTH + 2·popcount(B)`.
- Adder stalls add cycles one for one.
- Back-to-back operation: with `O_ACK` high in the first DONE cycle, the next `I_ACK` can occur the cycle after.
- Operands are captured at accept; `I_DAT_*` may change freely afterwards.

## Configuration
- `MUL_EARLY_EXIT_EN` defined:
  - In SCAN, `MPLIER==0` goes directly to DONE.
  - At a shift step, a shifted `MPLIER` of 0 goes directly to DONE.
  - Latency becomes `1 + (msb_index(B)+1) + 2·popcount(B)`.
  - `B==0` gives latency 2.
- `MUL_EARLY_EXIT_EN` undefined:
  - All `B_WIDTH` bits are always scanned.
  - Latency is fixed by popcount only.
  - `B==0` gives latency `1+B_WIDTH`.
- The product value is identical in both builds.

## Test plan
- A=3, B=5, `O_ACK`=1, zero-wait adder → `O_DAT`=15. `O_STB` rises 37 cycles after accept (8 with `MUL_EARLY_EXIT_EN`). Exactly 2 adder transfers.
- A=0xFFFFFFFF, B=0xFFFFFFFF → `O_DAT`=0xFFFFFFFE00000001. `O_STB` rises 97 cycles after accept. 32 adder transfers.
- A=0x1234, B=0 → `O_DAT`=0. `O_STB` rises after 33 cycles (2 with early exit). Zero adder transfers.
- A=7, B=6, `O_ACK` held low 10 cycles in DONE → `O_STB`=1 and `O_DAT`=42 stable throughout. `I_ACK`=0 despite `I_STB`=1. Next operand pair accepted the cycle after `O_ACK`.
- Adder `ADD_ACK` stalled 5 cycles on the first request, A=9, B=3 → `ADD_STB`/`ADD_DAT_*` stable while stalled. `O_DAT`=27. Latency grows by exactly 5.
- `RST` pulsed during ADD_WAIT of A=5, B=5 → all outputs 0 next cycle, no `O_STB`. A following A=2, B=2 yields `O_DAT`=4.

Source files
------------

// File: rtl/mul_shift_add.sv
// Sequential shift-and-add unsigned multiplier driving an external two-operand adder.
// Optional build macro MUL_EARLY_EXIT_EN stops scanning once no multiplier bits remain set.
module mul_shift_add #(
  parameter  int A_WIDTH = 32,
  parameter  int B_WIDTH = 32,
  localparam int P_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               i_stb_i,
  output logic               i_ack_o,
  input  logic [A_WIDTH-1:0] i_dat_a_i,
  input  logic [B_WIDTH-1:0] i_dat_b_i,
  output logic               add_stb_o,
  input  logic               add_ack_i,
  output logic [P_WIDTH-1:0] add_dat_a_o,
  output logic [P_WIDTH-1:0] add_dat_b_o,
  input  logic               add_res_stb_i,
  input  logic [P_WIDTH:0]   add_res_dat_i,
  output logic               add_res_ack_o,
  output logic               o_stb_o,
  output logic [P_WIDTH-1:0] o_dat_o,
  input  logic               o_ack_i
);

  localparam int CNT_W = $clog2(B_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ADD_REQ,
    ADD_WAIT,
    DONE
  } state_t;

  state_t             state_q;
  logic [P_WIDTH-1:0] mcand_q;
  logic [B_WIDTH-1:0] mplier_q;
  logic [P_WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               add_stb_q;
  logic [P_WIDTH-1:0] add_dat_a_q;
  logic [P_WIDTH-1:0] add_dat_b_q;
  logic               o_stb_q;
  logic [P_WIDTH-1:0] o_dat_q;

  logic [P_WIDTH-1:0] mcand_d;
  logic [B_WIDTH-1:0] mplier_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [P_WIDTH-1:0] acc_d;
  logic               step_en;
  logic               step_last;
  logic               scan_empty;

  // The adder carry-out is never needed: the product always fits in P_WIDTH.
  logic unused_res_msb;
  assign unused_res_msb = add_res_dat_i[P_WIDTH];

  assign i_ack_o       = i_stb_i & (state_q == IDLE);
  assign add_res_ack_o = add_res_stb_i & ((state_q == IDLE) | (state_q == ADD_WAIT));
  assign add_stb_o     = add_stb_q;
  assign add_dat_a_o   = add_dat_a_q;
  assign add_dat_b_o   = add_dat_b_q;
  assign o_stb_o       = o_stb_q;
  assign o_dat_o       = o_dat_q;

  assign mcand_d  = mcand_q << 1;
  assign mplier_d = mplier_q >> 1;
  assign cnt_d    = cnt_q + CNT_W'(1);
  assign acc_d    = (state_q == ADD_WAIT) ? add_res_dat_i[P_WIDTH-1:0] : acc_q;

  // A shift step happens on a clear bit in SCAN, or when the sum returns in ADD_WAIT.
  assign step_en = ((state_q == SCAN) && !scan_empty && !mplier_q[0]) ||
                   ((state_q == ADD_WAIT) && add_res_stb_i);

`ifdef MUL_EARLY_EXIT_EN
  assign scan_empty = (mplier_q == '0);
  assign step_last  = (cnt_q == CNT_LAST) || (mplier_d == '0);
`else
  assign scan_empty = 1'b0;
  assign step_last  = (cnt_q == CNT_LAST);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      add_stb_q   <= 1'b0;
      add_dat_a_q <= '0;
      add_dat_b_q <= '0;
      o_stb_q     <= 1'b0;
      o_dat_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_ack_o) begin
            mcand_q  <= {{B_WIDTH{1'b0}}, i_dat_a_i};
            mplier_q <= i_dat_b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= SCAN;
          end
        end
        SCAN: begin
          if (scan_empty) begin
            state_q <= DONE;
            o_stb_q <= 1'b1;
            o_dat_q <= acc_q;
          end else if (mplier_q[0]) begin
            state_q     <= ADD_REQ;
            add_stb_q   <= 1'b1;
            add_dat_a_q <= acc_q;
            add_dat_b_q <= mcand_q;
          end
        end
        ADD_REQ: begin
          if (add_ack_i) begin
            add_stb_q <= 1'b0;
            state_q   <= ADD_WAIT;
          end
        end
        DONE: begin
          if (o_ack_i) begin
            o_stb_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= state_q;
      endcase

      if (step_en) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        cnt_q    <= cnt_d;
        if (step_last) begin
          state_q <= DONE;
          o_stb_q <= 1'b1;
          o_dat_q <= acc_d;
        end else begin
          state_q <= SCAN;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_shift_add.sv
// Randomised scoreboard bench for mul_shift_add with a behavioural adder and product model.
module tb_mul_shift_add;

  localparam int AW = 32;
  localparam int BW = 32;
  localparam int PW = AW + BW;
`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_stb = 1'b0;
  logic          i_ack;
  logic [AW-1:0] i_dat_a = '0;
  logic [BW-1:0] i_dat_b = '0;
  logic          add_stb;
  logic          add_ack;
  logic [PW-1:0] add_dat_a;
  logic [PW-1:0] add_dat_b;
  logic          res_stb;
  logic [PW:0]   res_dat;
  logic          res_ack;
  logic          o_stb;
  logic [PW-1:0] o_dat;
  logic          o_ack;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int stall_first = 0;
  int stall_left = 0;
  int ack_delay = 0;
  int hold_cnt = 0;
  int op_num = 0;

  mul_shift_add #(.A_WIDTH(AW), .B_WIDTH(BW)) dut (
    .clk_i(clk), .rst_i(rst),
    .i_stb_i(i_stb), .i_ack_o(i_ack), .i_dat_a_i(i_dat_a), .i_dat_b_i(i_dat_b),
    .add_stb_o(add_stb), .add_ack_i(add_ack), .add_dat_a_o(add_dat_a), .add_dat_b_o(add_dat_b),
    .add_res_stb_i(res_stb), .add_res_dat_i(res_dat), .add_res_ack_o(res_ack),
    .o_stb_o(o_stb), .o_dat_o(o_dat), .o_ack_i(o_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural adder: stalls the first request(s) of an operation, sum valid next cycle.
  assign add_ack = add_stb && (stall_left == 0);
  always @(posedge clk) begin
    if (rst) begin
      res_stb    <= 1'b0;
      res_dat    <= '0;
      stall_left <= 0;
    end else begin
      if (i_stb && i_ack) stall_left <= stall_first;
      else if (add_stb && stall_left > 0) stall_left <= stall_left - 1;
      if (res_stb && res_ack) res_stb <= 1'b0;
      if (add_stb && add_ack) begin
        res_stb <= 1'b1;
        res_dat <= {1'b0, add_dat_a} + {1'b0, add_dat_b};
      end
    end
  end

  // Product sink: holds O_ACK low for ack_delay cycles of O_STB.
  assign o_ack = o_stb && (hold_cnt >= ack_delay);
  always @(posedge clk) begin
    if (o_stb && !o_ack) hold_cnt <= hold_cnt + 1;
    else hold_cnt <= 0;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [PW-1:0] prod;
    int            lat;
    int            acc_cycle;
  } exp_t;
  typedef struct {
    logic [PW-1:0] acc;
    logic [PW-1:0] mc;
  } add_t;

  exp_t exp_q[$];
  add_t add_q[$];

  logic          o_seen = 1'b0;
  logic [PW-1:0] o_held = '0;
  logic          prev_stall = 1'b0;
  logic [127:0]  prev_add = '0;

  // Reference: product by plain multiplication, adder traffic from the set bits of B.
  task automatic model_push(input logic [AW-1:0] a, input logic [BW-1:0] b, input int stall);
    exp_t e;
    logic [PW-1:0] acc;
    int pop;
    int msb;
    int scan;
    acc = '0;
    pop = 0;
    msb = -1;
    for (int i = 0; i < BW; i++) begin
      if (b[i]) begin
        add_q.push_back('{acc, PW'(a) << i});
        acc = acc + (PW'(a) << i);
        pop++;
        msb = i;
      end
    end
    if (EARLY) scan = (b == '0) ? 1 : msb + 1;
    else scan = BW;
    e.a = a;
    e.b = b;
    e.prod = PW'(a) * PW'(b);
    e.lat = 1 + scan + 2 * pop + ((pop > 0) ? stall : 0);
    e.acc_cycle = cycle;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      add_q.delete();
      o_seen = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (i_stb && i_ack) model_push(i_dat_a, i_dat_b, stall_first);
      if (prev_stall) begin
        check("add_stb_hold", 128'(add_stb), 128'(1));
        check("add_dat_hold", {add_dat_a, add_dat_b}, prev_add);
      end
      prev_stall = add_stb && !add_ack;
      prev_add = {add_dat_a, add_dat_b};
      if (add_stb && add_ack) begin
        if (add_q.size() == 0) fail_now("spurious_add_request");
        else begin
          add_t r;
          r = add_q.pop_front();
          check("add_dat_a", 128'(add_dat_a), 128'(r.acc));
          check("add_dat_b", 128'(add_dat_b), 128'(r.mc));
        end
      end
      if (o_stb) begin
        if (!o_seen) begin
          o_seen = 1'b1;
          o_held = o_dat;
          if (exp_q.size() == 0) fail_now("spurious_o_stb");
          else begin
            exp_t e;
            e = exp_q.pop_front();
            op_num++;
            $display("op %0d: A=%0h B=%0h product=%0h latency=%0d", op_num, e.a, e.b, o_dat,
                     cycle - e.acc_cycle);
            check("product", 128'(o_dat), 128'(e.prod));
            check("latency", 128'(cycle - e.acc_cycle), 128'(e.lat));
            check("adder_transfers_left", 128'(add_q.size()), 128'(0));
          end
        end else begin
          check("o_dat_hold", 128'(o_dat), 128'(o_held));
        end
        if (o_ack) o_seen = 1'b0;
      end
    end
  end

  task automatic wait_accept();
    bit got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (i_ack) got = 1'b1;
    end
    if (!got) fail_now("timeout_accept");
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (o_stb && o_ack) got = 1'b1;
    end
    if (!got) fail_now("timeout_output");
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [AW-1:0] a, input logic [BW-1:0] b, input int stall, input int dly);
    stall_first = stall;
    ack_delay = dly;
    i_dat_a = a;
    i_dat_b = b;
    i_stb = 1'b1;
    wait_accept();
    @(posedge clk);
    #1;
    i_stb = 1'b0;
    i_dat_a = $urandom;
    i_dat_b = $urandom;
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_o_stb", 128'(o_stb), 128'(0));
    check("reset_o_dat", 128'(o_dat), 128'(0));
    check("reset_add_stb", 128'(add_stb), 128'(0));
    check("reset_add_dat", {add_dat_a, add_dat_b}, 128'(0));
    check("reset_i_ack", 128'(i_ack), 128'(0));
    @(posedge clk);
    #1;

    run_op(32'd3, 32'd5, 0, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(32'h1234, 32'd0, 0, 0);
    run_op(32'd9, 32'd3, 5, 0);

    // O_ACK held off in DONE while the next pair is already offered.
    begin
      bit seen = 1'b0;
      stall_first = 0;
      ack_delay = 10;
      i_dat_a = 32'd7;
      i_dat_b = 32'd6;
      i_stb = 1'b1;
      wait_accept();
      @(posedge clk);
      #1;
      i_dat_a = 32'd11;
      i_dat_b = 32'd13;
      for (int k = 0; k < 300 && !seen; k++) begin
        @(negedge clk);
        if (o_stb) seen = 1'b1;
      end
      if (!seen) fail_now("timeout_done_hold");
      for (int k = 0; k < 20 && !o_ack; k++) begin
        check("i_ack_busy", 128'(i_ack), 128'(0));
        @(negedge clk);
      end
      @(negedge clk);
      check("i_ack_back_to_back", 128'(i_ack), 128'(1));
      @(posedge clk);
      #1;
      i_stb = 1'b0;
      ack_delay = 0;
      wait_done();
    end

    // Reset while the first sum is outstanding abandons the operation.
    begin
      bit seen = 1'b0;
      stall_first = 0;
      ack_delay = 0;
      i_dat_a = 32'd5;
      i_dat_b = 32'd5;
      i_stb = 1'b1;
      wait_accept();
      @(posedge clk);
      #1;
      i_stb = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
        @(negedge clk);
        if (add_stb && add_ack) seen = 1'b1;
      end
      if (!seen) fail_now("timeout_add_request");
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_o_stb", 128'(o_stb), 128'(0));
      check("midrst_o_dat", 128'(o_dat), 128'(0));
      check("midrst_add_stb", 128'(add_stb), 128'(0));
      check("midrst_add_dat", {add_dat_a, add_dat_b}, 128'(0));
      repeat (40) @(negedge clk);
      @(posedge clk);
      #1;
      run_op(32'd2, 32'd2, 0, 0);
    end

    for (int n = 0; n < 24; n++) begin
      logic [BW-1:0] b;
      case (n % 4)
        0: b = $urandom;
        1: b = $urandom & $urandom & $urandom;
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = (n == 3) ? 32'd0 : 32'h8000_0000 >> $urandom_range(0, 31);
      endcase
      run_op($urandom, b, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (5) @(negedge clk);
    check("pending_products", 128'(exp_q.size()), 128'(0));
    check("pending_adder_requests", 128'(add_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
